note_sequencer: RTL and testbench

Song playback engine directly upstream of `sound_controller`. It steps through a song ROM of (note, duration, rest) entries under a beat timer. It drives the 4-bit `note` code and `make_sound` enable that `sound_controller` turns into a square wave. It inserts a short silent gap at the end of every note, so repeated notes are audible as separate notes. It exposes beat and note-index status for the game logic.

---
 rtl/note_seq_pkg.sv | 46 ++++
 rtl/song_rom.sv | 27 ++
 rtl/note_sequencer.sv | 175 +++++++++++++++++
 tb/tb_note_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: note codes understood by sound_controller,
// song ROM entry layout and the sequencer state encoding.
package note_seq_pkg;

  localparam int ENTRY_W   = 9;
  localparam int NOTE_LSB  = 0;
  localparam int NOTE_W    = 4;
  localparam int BEATS_LSB = 4;
  localparam int BEATS_W   = 4;
  localparam int REST_BIT  = 8;

  // A zero beat count marks the end of the song.
  localparam logic [BEATS_W-1:0] BEATS_END = 4'd0;

  localparam logic [NOTE_W-1:0] NOTE_C4  = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_D4  = 4'h1;
  localparam logic [NOTE_W-1:0] NOTE_E4  = 4'h2;
  localparam logic [NOTE_W-1:0] NOTE_F4  = 4'h3;
  localparam logic [NOTE_W-1:0] NOTE_G4  = 4'h4;
  localparam logic [NOTE_W-1:0] NOTE_A4  = 4'h5;
  localparam logic [NOTE_W-1:0] NOTE_B4  = 4'h6;
  localparam logic [NOTE_W-1:0] NOTE_C5  = 4'h7;
  localparam logic [NOTE_W-1:0] NOTE_D5  = 4'h8;
  localparam logic [NOTE_W-1:0] NOTE_E5  = 4'h9;
  localparam logic [NOTE_W-1:0] NOTE_F5  = 4'hA;
  localparam logic [NOTE_W-1:0] NOTE_G5  = 4'hB;
  localparam logic [NOTE_W-1:0] NOTE_CS4 = 4'hC;
  localparam logic [NOTE_W-1:0] NOTE_DS4 = 4'hD;
  localparam logic [NOTE_W-1:0] NOTE_FS4 = 4'hE;
  localparam logic [NOTE_W-1:0] NOTE_GS4 = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic rest,
                                                    input logic [BEATS_W-1:0] beats,
                                                    input logic [NOTE_W-1:0] code);
    return {rest, beats, code};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM, 2^ADDR_W entries of 9 bits. Contents come from ROM_IMAGE
// (entry k at bits [9k +: 9]), which synthesises to a constant ROM.
module song_rom
  import note_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter logic [ENTRY_W*(2**ADDR_W)-1:0] ROM_IMAGE = '0
) (
  input  logic                clock,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [ENTRY_W-1:0]  o_data
);

  logic [ENTRY_W-1:0] w_mem [2**ADDR_W];
  logic [ENTRY_W-1:0] r_data;

  for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_mem
    assign w_mem[k] = ROM_IMAGE[k*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clock) begin
    r_data <= w_mem[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Song playback engine feeding sound_controller: walks the song ROM under a beat timer,
// with a silent gap closing each note. Define NOTE_SEQ_LOOP_EN to loop the song at its end marker.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int ADDR_W      = 6,
  parameter logic [ENTRY_W*(2**ADDR_W)-1:0] ROM_IMAGE = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [3:0]        note,
  output logic              make_sound,
  output logic              playing,
  output logic              beat_tick,
  output logic [ADDR_W-1:0] note_index,
  output logic              song_done,
  output state_t            o_dbg_state
);

  localparam int REM_W  = $clog2(15 * BEAT_CYCLES);
  localparam int BEAT_W = $clog2(BEAT_CYCLES);
  localparam logic [REM_W-1:0]  GAP_VAL   = REM_W'(GAP_CYCLES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [31:0]       BEAT_U    = 32'(BEAT_CYCLES);

  state_t              r_state, w_state_next;
  logic                r_start;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [REM_W-1:0]    r_rem, w_rem_next, w_rem_load;
  logic [BEAT_W-1:0]   r_beat, w_beat_next;
  logic [NOTE_W-1:0]   r_note, w_note_next;
  logic                r_rest, w_rest_next;
  logic                r_make_sound, w_make_sound_next;
  logic                r_playing, w_playing_next;
  logic                r_beat_tick, w_tick_next;
  logic                r_song_done, w_done_next;
  logic                w_paused;
  logic [ENTRY_W-1:0]  w_rom_data;
  logic [NOTE_W-1:0]   w_rom_note;
  logic [BEATS_W-1:0]  w_rom_beats;
  logic                w_rom_rest;

  // The ROM is addressed with the next address so the entry is ready during FETCH.
  song_rom #(
    .ADDR_W    (ADDR_W),
    .ROM_IMAGE (ROM_IMAGE)
  ) u_song_rom (
    .clock  (clock),
    .i_addr (w_addr_next),
    .o_data (w_rom_data)
  );

  assign w_rom_note  = w_rom_data[NOTE_LSB +: NOTE_W];
  assign w_rom_beats = w_rom_data[BEATS_LSB +: BEATS_W];
  assign w_rom_rest  = w_rom_data[REST_BIT];
  assign w_rem_load  = REM_W'(32'(w_rom_beats) * BEAT_U - 32'd1);
  assign w_paused    = pause && ((r_state == ST_PLAY) || (r_state == ST_GAP));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_start      <= 1'b0;
      r_addr       <= '0;
      r_rem        <= '0;
      r_beat       <= '0;
      r_note       <= '0;
      r_rest       <= 1'b0;
      r_make_sound <= 1'b0;
      r_playing    <= 1'b0;
      r_beat_tick  <= 1'b0;
      r_song_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_start      <= start && !stop;
      r_addr       <= w_addr_next;
      r_rem        <= w_rem_next;
      r_beat       <= w_beat_next;
      r_note       <= w_note_next;
      r_rest       <= w_rest_next;
      r_make_sound <= w_make_sound_next;
      r_playing    <= w_playing_next;
      r_beat_tick  <= w_tick_next;
      r_song_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (stop) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (r_start) w_state_next = ST_FETCH;
        ST_FETCH: begin
          if (w_rom_beats == BEATS_END) begin
`ifdef NOTE_SEQ_LOOP_EN
            w_state_next = ST_FETCH;
`else
            w_state_next = ST_DONE;
`endif
          end else begin
            w_state_next = ST_PLAY;
          end
        end
        // With no gap configured, the note ends straight from PLAY.
        ST_PLAY: if (!pause && (r_rem == GAP_VAL))
          w_state_next = (GAP_CYCLES == 0) ? ST_FETCH : ST_GAP;
        ST_GAP: if (!pause && (r_rem == '0)) w_state_next = ST_FETCH;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr_next = r_addr;
    w_rem_next  = r_rem;
    w_beat_next = r_beat;
    w_note_next = r_note;
    w_rest_next = r_rest;
    w_tick_next = 1'b0;
    w_done_next = 1'b0;
    if (stop) begin
      w_addr_next = '0;
      w_rem_next  = '0;
      w_beat_next = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (r_start) w_addr_next = '0;
        ST_FETCH: begin
          w_beat_next = '0;
          if (w_rom_beats == BEATS_END) begin
            w_done_next = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
            w_addr_next = '0;
`endif
          end else begin
            w_note_next = w_rom_note;
            w_rest_next = w_rom_rest;
            w_rem_next  = w_rem_load;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (!pause) begin
            if (r_rem != '0) w_rem_next = r_rem - REM_W'(1);
            if (w_state_next == ST_FETCH) w_addr_next = r_addr + ADDR_W'(1);
            if (r_beat == BEAT_LAST) begin
              w_beat_next = '0;
              w_tick_next = 1'b1;
            end else begin
              w_beat_next = r_beat + BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    w_make_sound_next = (w_state_next == ST_PLAY) && !w_rest_next && !w_paused;
    w_playing_next    = (w_state_next == ST_FETCH) || (w_state_next == ST_PLAY) ||
                        (w_state_next == ST_GAP);
  end

  assign note        = r_note;
  assign make_sound  = r_make_sound;
  assign playing     = r_playing;
  assign beat_tick   = r_beat_tick;
  assign note_index  = r_addr;
  assign song_done   = r_song_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: BEAT_CYCLES=10, GAP_CYCLES=2 on song {C4x1, D4x2, rest x1, end},
// plus a 4-entry song with no end marker (BEAT_CYCLES=4, GAP_CYCLES=1) for address wrap.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam logic [35:0] ROM1 = {ENTRY_W'(0), make_entry(1'b1, 4'd1, NOTE_E4),
                                  make_entry(1'b0, 4'd2, NOTE_D4), make_entry(1'b0, 4'd1, NOTE_C4)};
  localparam logic [35:0] ROM2 = {make_entry(1'b0, 4'd1, NOTE_A4), make_entry(1'b0, 4'd1, NOTE_G4),
                                  make_entry(1'b0, 4'd1, NOTE_F4), make_entry(1'b0, 4'd1, NOTE_E4)};

  logic       clock, resetn;
  logic       start, stop, pause;
  logic [3:0] note;
  logic       make_sound, playing, beat_tick, song_done;
  logic [1:0] note_index;
  state_t     st1;
  logic       start2, stop2, pause2;
  logic [3:0] note2;
  logic       ms2, playing2, tick2, done2;
  logic [1:0] idx2;
  state_t     st2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] tr_ms, tr_tick, tr_done, tr_play;
  logic [3:0]  tr_note [64];
  logic [1:0]  tr_idx  [64];
  state_t      tr_st   [64];
  logic [1:0]  exp_q [$];

  note_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .ADDR_W(2), .ROM_IMAGE(ROM1)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
    .note(note), .make_sound(make_sound), .playing(playing), .beat_tick(beat_tick),
    .note_index(note_index), .song_done(song_done), .o_dbg_state(st1)
  );

  note_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(1), .ADDR_W(2), .ROM_IMAGE(ROM2)) u_dut_wrap (
    .clock(clock), .resetn(resetn), .start(start2), .stop(stop2), .pause(pause2),
    .note(note2), .make_sound(ms2), .playing(playing2), .beat_tick(tick2),
    .note_index(idx2), .song_done(done2), .o_dbg_state(st2)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit_at(input int b);
    logic [63:0] m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Driver: pulse start on DUT1, then record one sample per cycle on the falling edge.
  task automatic capture(input int n, input int pause_at, input int stop_at);
    tr_ms = '0; tr_tick = '0; tr_done = '0; tr_play = '0;
    start = 1'b1;
    for (int s = 0; s < n; s++) begin
      @(posedge clock);
      @(negedge clock);
      tr_ms[s] = make_sound; tr_tick[s] = beat_tick;
      tr_done[s] = song_done; tr_play[s] = playing;
      tr_note[s] = note; tr_idx[s] = note_index; tr_st[s] = st1;
      if (s == 0) start = 1'b0;
      if (s == pause_at) pause = 1'b1;
      if (pause_at >= 0 && s == pause_at + 5) pause = 1'b0;
      if (s == stop_at) begin stop = 1'b1; start = 1'b1; end
      if (stop_at >= 0 && s == stop_at + 1) begin stop = 1'b0; start = 1'b0; end
    end
  endtask

  task automatic go_idle();
    stop = 1'b1;
    @(posedge clock);
    @(negedge clock);
    stop = 1'b0;
  endtask

  initial begin
    logic [63:0] m45, m50;
    logic [1:0]  prev;
    m45 = span(0, 45);
    m50 = span(0, 50);
    resetn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; pause2 = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_note", 64'(note), 64'(0));
    check("rst_make_sound", 64'(make_sound), 64'(0));
    check("rst_playing", 64'(playing), 64'(0));
    check("rst_beat_tick", 64'(beat_tick), 64'(0));
    check("rst_song_done", 64'(song_done), 64'(0));
    check("rst_note_index", 64'(note_index), 64'(0));
    check("rst_state", 64'(st1), 64'(ST_IDLE));
    resetn = 1'b1;
    @(negedge clock);

    // Full song playback
    capture(64, -1, -1);
    check("t1_make_sound", tr_ms & m45, span(2, 9) | span(13, 30));
    check("t1_beat_tick", tr_tick & m45, bit_at(12) | bit_at(23) | bit_at(33) | bit_at(44));
    check("t1_song_done", tr_done & m45, bit_at(45));
    check("t1_playing", tr_play & m45, span(1, 44));
    check("t1_note_c4", 64'(tr_note[5]), 64'(NOTE_C4));
    check("t1_note_d4", 64'(tr_note[20]), 64'(NOTE_D4));
    check("t1_note_rest", 64'(tr_note[40]), 64'(NOTE_E4));
    check("t1_idx_e0", 64'(tr_idx[5]), 64'(0));
    check("t1_idx_e1", 64'(tr_idx[12]), 64'(1));
    check("t1_idx_e2", 64'(tr_idx[35]), 64'(2));
    check("t1_idx_end", 64'(tr_idx[44]), 64'(3));
    check("t1_st_fetch", 64'(tr_st[1]), 64'(ST_FETCH));
    check("t1_st_play", 64'(tr_st[5]), 64'(ST_PLAY));
    check("t1_st_gap", 64'(tr_st[10]), 64'(ST_GAP));
`ifdef NOTE_SEQ_LOOP_EN
    check("t1_loop_st", 64'(tr_st[45]), 64'(ST_FETCH));
    check("t1_loop_ms", tr_ms & span(46, 53), span(46, 53));
    check("t1_loop_note", 64'(tr_note[50]), 64'(NOTE_C4));
`else
    check("t1_done_st", 64'(tr_st[50]), 64'(ST_DONE));
    check("t1_done_ms", tr_ms & span(46, 63), 64'(0));
    check("t1_done_once", tr_done & span(46, 63), 64'(0));
`endif
    go_idle();

    // Pause for 5 cycles in the middle of D4
    capture(64, 18, -1);
    check("t2_make_sound", tr_ms & m50, span(2, 9) | span(13, 18) | span(24, 35));
    check("t2_beat_tick", tr_tick & m50, bit_at(12) | bit_at(28) | bit_at(38) | bit_at(49));
    check("t2_song_done", tr_done & m50, bit_at(50));
    check("t2_st_paused", 64'(tr_st[21]), 64'(ST_PLAY));
    check("t2_note_paused", 64'(tr_note[21]), 64'(NOTE_D4));
    go_idle();

    // stop together with start during the D4 gap
    capture(64, -1, 31);
    check("t3_make_sound", tr_ms, span(2, 9) | span(13, 30));
    check("t3_song_done", tr_done, 64'(0));
    check("t3_playing", tr_play, span(1, 31));
    check("t3_beat_tick", tr_tick, bit_at(12) | bit_at(23));
    check("t3_st_gap", 64'(tr_st[31]), 64'(ST_GAP));
    check("t3_idx_before", 64'(tr_idx[31]), 64'(1));
    check("t3_idx_after", 64'(tr_idx[32]), 64'(0));
    check("t3_st_idle", 64'(tr_st[32]), 64'(ST_IDLE));
    check("t3_st_stays", 64'(tr_st[63]), 64'(ST_IDLE));

    // Asynchronous reset in the middle of D4
    start = 1'b1;
    for (int s = 0; s <= 20; s++) begin
      @(posedge clock);
      @(negedge clock);
      if (s == 0) start = 1'b0;
    end
    check("t4_pre_ms", 64'(make_sound), 64'(1));
    check("t4_pre_note", 64'(note), 64'(NOTE_D4));
    #2 resetn = 1'b0;
    #1;
    check("t4_async_ms", 64'(make_sound), 64'(0));
    check("t4_async_note", 64'(note), 64'(0));
    check("t4_async_idx", 64'(note_index), 64'(0));
    repeat (3) @(negedge clock);
    check("t4_hold_playing", 64'(playing), 64'(0));
    check("t4_hold_state", 64'(st1), 64'(ST_IDLE));
    resetn = 1'b1;
    @(negedge clock);
    check("t4_post_ms", 64'(make_sound), 64'(0));

    // Address wrap on the song without an end marker
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    tr_ms = '0;
    prev = '0;
    start2 = 1'b1;
    for (int s = 0; s < 40; s++) begin
      @(posedge clock);
      @(negedge clock);
      tr_ms[s] = ms2; tr_note[s] = note2;
      if (s == 0) start2 = 1'b0;
      if (s == 0 || idx2 != prev) begin
        if (exp_q.size() == 0) check("wrap_extra_idx", 64'(idx2), 64'hFF);
        else check("wrap_idx", 64'(idx2), 64'(exp_q.pop_front()));
      end
      prev = idx2;
    end
    check("wrap_q_left", 64'(exp_q.size()), 64'(0));
    check("wrap_make_sound", tr_ms & span(0, 20),
          span(2, 4) | span(7, 9) | span(12, 14) | span(17, 19));
    check("wrap_note_last", 64'(tr_note[17]), 64'(NOTE_A4));
    check("wrap_note_first", 64'(tr_note[22]), 64'(NOTE_E4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
